bmem_line_adapter: RTL and testbench
====================================

// Module: bmem_line_adapter
// PURPOSE
// - Sits between the I-cache/D-cache miss ports and the banked burst DRAM interface.
// - Arbitrates two line-request clients and serializes 256-bit line writes into 4x64-bit beats.
// - Deserializes 4-beat read bursts, which may complete out of order and are tagged by raddr,
//   back into 256-bit lines for the owning client.
// PARAMETERS
// - ADDR_W  32   byte-address width
// - BEAT_W  64   bmem data width per beat
// - BEATS   4    beats per line (line = BEAT_W*BEATS = 256 b; line-aligned on addr[4:0])
// PORTS
// - clk             in   1        clock; all logic on posedge
// - rst             in   1        synchronous, active-high reset
// - cl_read[i]      in   1        client i (0=icache, 1=dcache) line read request, i=0..1
// - cl_write[i]     in   1        client i line write request (never with cl_read[i])
// - cl_addr[i]      in   ADDR_W   line address; bits [4:0] ignored and driven 0 on bmem_addr
// - cl_wdata[i]     in   256      write line; beat k = cl_wdata[i][64k+63:64k]
// - cl_resp[i]      out  1        one-cycle completion pulse (read data valid / write done)
// - cl_rdata[i]     out  256      read line; valid while cl_resp[i]=1
// - bmem_addr       out  ADDR_W   request address
// - bmem_read       out  1        read request, one accepted cycle per burst
// - bmem_write      out  1        write beat strobe
// - bmem_wdata      out  BEAT_W   write beat data
// - bmem_ready      in   1        memory accepts read/write this cycle when high
// - bmem_raddr      in   ADDR_W   address tag of returning beat
// - bmem_rdata      in   BEAT_W   returning beat data
// - bmem_rvalid     in   1        returning beat valid
// - err_unexp       out  1        sticky: rvalid with raddr matching no pending read
// BEHAVIOUR
// - Reset: every output 0; issue FSM=IDLE; pending[1:0]=0; beat counters=0; err_unexp=0.
// - Client holds request/addr/wdata stable until its cl_resp; a client with a pending read
//   or an active write is not re-arbitrated.
// - Issue FSM: IDLE -> RD (bmem_read=1, addr) -> IDLE when bmem_ready; pending[i]<=1, paddr[i]<=addr.
//   IDLE -> WR0..WR3 (bmem_write=1, same line addr, beat k data); advance only on bmem_ready;
//   on WR3 accepted: cl_resp[i] pulses next cycle, then IDLE.
// - bmem_ready=0: bmem_* outputs held unchanged; no request dropped or duplicated.
// - Arbitration evaluated in IDLE only; grant registered; first bmem cycle is one cycle after request.
// - Return path: bursts arrive as BEATS consecutive rvalid cycles with constant raddr, never interleaved.
//   The first beat latches the match set = {i : pending[i] && paddr[i]==raddr}; beats
//   fill a 256-b shift buffer low beat first; after beat 3, cl_resp pulses for every
//   matched client on the next cycle, and their pending bits clear.
// - Both clients pending on the same line: a single burst satisfies both, with simultaneous cl_resp.
// - Empty match set: beats discarded; err_unexp<=1 (cleared only by rst).
// - Read return and write completion for different clients in the same cycle: both pulses issued.
// - Issue of a new read and a return for another client proceed concurrently (independent FSMs).
// - Reset mid-burst: counters, pending bits and buffer cleared; late beats after reset set err_unexp.
// CONFIGURATION
// - BMEM_ADAPTER_RR_EN defined: round-robin; last-granted client has lowest priority next IDLE.
// - Undefined: fixed priority, dcache (client 1) always wins over icache.
// TESTING
// - Single icache read 0x0000_1040; beats D0..D3 via raddr 0x1040 -> cl_rdata[0]={D3,D2,D1,D0}, one pulse.
// - dcache write 0x2000 with ready toggling 1,0,1,1,0,1 -> exactly 4 strobes, beats 0..3 in order, then cl_resp[1].
// - Reads icache 0x100, dcache 0x200; memory returns 0x200 burst first -> cl_resp[1] precedes cl_resp[0], data correct.
// - Simultaneous requests, 4 rounds: RR_EN grants alternate 1,0,1,0; without it, grant 1 every round.
// - Both clients read 0x300 -> one burst, both cl_resp high in the same cycle; rvalid raddr 0x999 -> err_unexp=1.
// - rst asserted after beat 1 of a return -> all outputs 0 next cycle; remaining beats set err_unexp.

Source files
------------

// File: rtl/bmem_line_adapter.sv
// bmem_line_adapter: two-client line adapter onto a 4-beat burst memory; define BMEM_ADAPTER_RR_EN for round-robin arbitration
module bmem_line_adapter #(
    parameter int ADDR_W = 32,
    parameter int BEAT_W = 64,
    parameter int BEATS  = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [1:0]                       cl_read,
    input  logic [1:0]                       cl_write,
    input  logic [1:0][ADDR_W-1:0]           cl_addr,
    input  logic [1:0][BEAT_W*BEATS-1:0]     cl_wdata,
    output logic [1:0]                       cl_resp,
    output logic [1:0][BEAT_W*BEATS-1:0]     cl_rdata,
    output logic [ADDR_W-1:0]                bmem_addr,
    output logic                             bmem_read,
    output logic                             bmem_write,
    output logic [BEAT_W-1:0]                bmem_wdata,
    input  logic                             bmem_ready,
    input  logic [ADDR_W-1:0]                bmem_raddr,
    input  logic [BEAT_W-1:0]                bmem_rdata,
    input  logic                             bmem_rvalid,
    output logic                             err_unexp
);
    localparam int LINE_W = BEAT_W * BEATS;
    localparam int OFF    = $clog2(LINE_W / 8);
    localparam int CW     = $clog2(BEATS);

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    state_t                   state_q, state_d;
    logic                     gnt_q, gnt_d;
    logic [CW-1:0]            wbeat_q, wbeat_d, rbeat_q;
    logic [1:0]               pend_q, match_q, resp_q, elig, wresp, rresp, match_now, cur_match, pend_set;
    logic [1:0][ADDR_W-1:0]   paddr_q;
    logic [LINE_W-1:0]        buf_q;
    logic                     err_q, rd_acc;
    logic [ADDR_W-1:0]        line_addr;
    logic                     unused_lo;

    assign unused_lo = ^{cl_addr[0][OFF-1:0], cl_addr[1][OFF-1:0]};
    assign line_addr = {cl_addr[gnt_q][ADDR_W-1:OFF], {OFF{1'b0}}};
    // a client already waiting on a read, or seeing its completion pulse, must not be granted again
    assign elig      = (cl_read | cl_write) & ~pend_q & ~resp_q;
    assign rd_acc    = state_q == RD && bmem_ready;
    assign pend_set  = rd_acc ? (2'b01 << gnt_q) : 2'b00;
    assign cl_resp   = resp_q;
    assign err_unexp = err_q;
    assign cl_rdata[0] = resp_q[0] ? buf_q : '0;
    assign cl_rdata[1] = resp_q[1] ? buf_q : '0;

    // issue FSM: grant in IDLE, then one read request or a train of write beats held until accepted
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        wbeat_d    = wbeat_q;
        wresp      = '0;
        bmem_addr  = '0;
        bmem_read  = 1'b0;
        bmem_write = 1'b0;
        bmem_wdata = '0;
        case (state_q)
            IDLE: if (|elig) begin
`ifdef BMEM_ADAPTER_RR_EN
                gnt_d   = &elig ? ~gnt_q : elig[1];
`else
                gnt_d   = elig[1];
`endif
                state_d = cl_write[gnt_d] ? WR : RD;
                wbeat_d = '0;
            end
            RD: begin
                bmem_addr = line_addr;
                bmem_read = 1'b1;
                state_d   = bmem_ready ? IDLE : RD;
            end
            WR: begin
                bmem_addr  = line_addr;
                bmem_write = 1'b1;
                bmem_wdata = cl_wdata[gnt_q][int'(wbeat_q)*BEAT_W +: BEAT_W];
                if (bmem_ready) begin
                    wbeat_d = wbeat_q + 1'b1;
                    if (wbeat_q == CW'(BEATS-1)) begin
                        state_d      = IDLE;
                        wresp[gnt_q] = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // return path: the first beat of a burst fixes which pending clients it satisfies
    always_comb begin
        for (int i = 0; i < 2; i++) match_now[i] = pend_q[i] && paddr_q[i] == bmem_raddr;
        cur_match = rbeat_q == '0 ? match_now : match_q;
        rresp     = bmem_rvalid && rbeat_q == CW'(BEATS-1) ? cur_match : 2'b00;
    end

    // state, pending reads, beat buffer and sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            wbeat_q <= '0;
            rbeat_q <= '0;
            pend_q  <= '0;
            match_q <= '0;
            resp_q  <= '0;
            paddr_q <= '0;
            buf_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            wbeat_q <= wbeat_d;
            resp_q  <= wresp | rresp;
            pend_q  <= (pend_q & ~rresp) | pend_set;
            if (rd_acc) paddr_q[gnt_q] <= line_addr;
            if (bmem_rvalid) begin
                rbeat_q <= rbeat_q + 1'b1;
                buf_q   <= {bmem_rdata, buf_q[LINE_W-1:BEAT_W]};
                if (rbeat_q == '0) begin
                    match_q <= match_now;
                    if (match_now == 2'b00) err_q <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_bmem_line_adapter.sv
// tb_bmem_line_adapter: directed vectors, corner sequences and a randomized run against a memory model
module tb_bmem_line_adapter;
    localparam int AW = 32, BW = 64, LW = 256;

    logic clk = 1'b0, rst;
    logic [1:0] cl_read, cl_write, cl_resp;
    logic [1:0][AW-1:0] cl_addr;
    logic [1:0][LW-1:0] cl_wdata, cl_rdata;
    logic [AW-1:0] bmem_addr, bmem_raddr;
    logic bmem_read, bmem_write, bmem_ready, bmem_rvalid, err_unexp;
    logic [BW-1:0] bmem_wdata, bmem_rdata;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    bmem_line_adapter dut (
        .clk(clk), .rst(rst), .cl_read(cl_read), .cl_write(cl_write), .cl_addr(cl_addr),
        .cl_wdata(cl_wdata), .cl_resp(cl_resp), .cl_rdata(cl_rdata), .bmem_addr(bmem_addr),
        .bmem_read(bmem_read), .bmem_write(bmem_write), .bmem_wdata(bmem_wdata),
        .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr), .bmem_rdata(bmem_rdata),
        .bmem_rvalid(bmem_rvalid), .err_unexp(err_unexp)
    );

    typedef struct {
        int           cl;
        logic [AW-1:0] addr;
        logic [AW-1:0] exp_addr;
        logic [1:0]    exp_resp;
        logic [LW-1:0] line;
    } vec_t;
    vec_t v[4];

    task automatic chk(input string n, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", n, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1; cl_read = 0; cl_write = 0; cl_addr = '0; cl_wdata = '0;
        bmem_ready = 1; bmem_rvalid = 0; bmem_raddr = '0; bmem_rdata = '0;
        tick; tick;
        rst = 0;
    endtask

    task automatic burst(input logic [AW-1:0] a, input logic [LW-1:0] line, input int lo, input int hi);
        for (int k = lo; k <= hi; k++) begin
            bmem_rvalid = 1; bmem_raddr = a; bmem_rdata = line[k*BW +: BW];
            tick;
        end
        bmem_rvalid = 0;
    endtask

    task automatic wait_rd(input string n, output logic [AW-1:0] a);
        int c;
        c = 0;
        while (!bmem_read && c < 20) begin tick; c++; end
        total++;
        if (!bmem_read) begin
            bad++;
            $display("FAIL %s: bmem_read got 0 want 1 within 20 cycles", n);
        end
        a = bmem_addr;
        tick;
    endtask

    function automatic logic [AW-1:0] ln(input logic [AW-1:0] a);
        return a & ~32'h1f;
    endfunction

    logic [LW-1:0] mem [logic [AW-1:0]];

    function automatic logic [LW-1:0] rdmem(input logic [AW-1:0] a);
        return mem.exists(a) ? mem[a] : {a * 7 + 3, a ^ 32'hdead, a + 11, ~a, a * 13, a ^ 32'h5a5a, a + 1, a};
    endfunction

    logic [AW-1:0] a, ba;
    logic [LW-1:0] wl, l0, l1, bl;
    logic [LW-1:0] wline[2];
    logic [1:0] busy, isw, expr;
    logic g, exp_g, o, allow;
    logic [AW-1:0] rq[$];
    int wcnt[2], done_n[2];
    int nacc, nresp, bk, idx;
    int pat[6] = '{1, 0, 1, 1, 0, 1};

    initial begin
        v[0] = '{0, 32'h0000_1040, 32'h0000_1040, 2'b01,
                 256'hd3d3d3d3_d3d3d3d3_d2d2d2d2_d2d2d2d2_d1d1d1d1_d1d1d1d1_d0d0d0d0_d0d0d0d0};
        v[1] = '{1, 32'h2000_005f, 32'h2000_0040, 2'b10,
                 256'h01234567_89abcdef_fedcba98_76543210_0f0f0f0f_f0f0f0f0_11112222_33334444};
        v[2] = '{0, 32'hffff_ffff, 32'hffff_ffe0, 2'b01,
                 256'hffffffff_ffffffff_00000000_00000001_80000000_00000000_deadbeef_cafef00d};
        v[3] = '{1, 32'h0000_0000, 32'h0000_0000, 2'b10,
                 256'h55555555_aaaaaaaa_12121212_34343434_56565656_78787878_9a9a9a9a_bcbcbcbc};

        do_reset;
        chk("rst_resp", cl_resp, 0);
        chk("rst_rdata0", cl_rdata[0], 0);
        chk("rst_rdata1", cl_rdata[1], 0);
        chk("rst_read", bmem_read, 0);
        chk("rst_write", bmem_write, 0);
        chk("rst_addr", bmem_addr, 0);
        chk("rst_wdata", bmem_wdata, 0);
        chk("rst_err", err_unexp, 0);

        for (int j = 0; j < 4; j++) begin
            cl_read[v[j].cl] = 1; cl_addr[v[j].cl] = v[j].addr;
            wait_rd("tbl_issue", a);
            chk("tbl_addr", a, v[j].exp_addr);
            tick;
            chk("tbl_no_reissue", bmem_read, 0);
            burst(v[j].exp_addr, v[j].line, 0, 3);
            chk("tbl_resp", cl_resp, v[j].exp_resp);
            chk("tbl_rdata", cl_rdata[v[j].cl], v[j].line);
            cl_read = 0;
            tick;
            chk("tbl_single_pulse", cl_resp, 0);
        end

        do_reset;
        wl = 256'h33333333_3333aaaa_22222222_2222bbbb_11111111_1111cccc_00000000_0000dddd;
        cl_write[1] = 1; cl_addr[1] = 32'h2000; cl_wdata[1] = wl;
        nacc = 0; nresp = 0;
        tick;
        for (int c = 0; c < 12 && nresp == 0; c++) begin
            bmem_ready = c < 6 ? pat[c][0] : 1'b1;
            #1;
            if (bmem_write && bmem_ready) begin
                chk("wr_beat", bmem_wdata, nacc < 4 ? wl[nacc*BW +: BW] : '0);
                chk("wr_addr", bmem_addr, 32'h2000);
                nacc++;
            end
            tick;
            if (cl_resp[1]) nresp++;
        end
        chk("wr_strobes", nacc, 4);
        chk("wr_resp", cl_resp, 2'b10);
        chk("wr_idle_after", bmem_write, 0);
        bmem_ready = 1; cl_write = 0;
        tick;
        chk("wr_single_pulse", cl_resp, 0);

        do_reset;
        l0 = {8{32'h0100_aa55}}; l1 = {8{32'h0200_5a5a}};
        cl_read = 2'b11; cl_addr[0] = 32'h100; cl_addr[1] = 32'h200;
        wait_rd("ooo_first", a);
        chk("ooo_first_addr", a, 32'h200);
        wait_rd("ooo_second", a);
        chk("ooo_second_addr", a, 32'h100);
        burst(32'h200, l1, 0, 3);
        chk("ooo_resp1", cl_resp, 2'b10);
        chk("ooo_rdata1", cl_rdata[1], l1);
        cl_read[1] = 0;
        tick;
        burst(32'h100, l0, 0, 3);
        chk("ooo_resp0", cl_resp, 2'b01);
        chk("ooo_rdata0", cl_rdata[0], l0);
        cl_read = 0;
        tick;

        do_reset;
        for (int r = 0; r < 4; r++) begin
            cl_read = 2'b11; cl_addr[0] = 32'h500; cl_addr[1] = 32'h600;
            tick;
            chk("arb_read", bmem_read, 1);
            g = bmem_addr == 32'h600;
`ifdef BMEM_ADAPTER_RR_EN
            exp_g = r % 2 == 0;
`else
            exp_g = 1'b1;
`endif
            chk("arb_grant", g, exp_g);
            cl_read = g ? 2'b10 : 2'b01;
            tick;
            burst(g ? 32'h600 : 32'h500, l0, 0, 3);
            chk("arb_resp", cl_resp, g ? 2'b10 : 2'b01);
            cl_read = 0;
            tick;
        end

        do_reset;
        cl_read = 2'b11; cl_addr[0] = 32'h300; cl_addr[1] = 32'h300;
        wait_rd("same_first", a);
        chk("same_first_addr", a, 32'h300);
        wait_rd("same_second", a);
        chk("same_second_addr", a, 32'h300);
        burst(32'h300, l1, 0, 3);
        chk("same_resp", cl_resp, 2'b11);
        chk("same_rdata0", cl_rdata[0], l1);
        chk("same_rdata1", cl_rdata[1], l1);
        chk("same_no_err", err_unexp, 0);
        cl_read = 0;
        tick;
        burst(32'h999, l0, 0, 3);
        chk("unexp_resp", cl_resp, 0);
        chk("unexp_err", err_unexp, 1);
        tick; tick;
        chk("unexp_sticky", err_unexp, 1);

        do_reset;
        cl_read[0] = 1; cl_addr[0] = 32'h400;
        wait_rd("rstmid_issue", a);
        burst(32'h400, l0, 0, 1);
        rst = 1; cl_read = 0;
        tick;
        chk("rstmid_resp", cl_resp, 0);
        chk("rstmid_rdata0", cl_rdata[0], 0);
        chk("rstmid_read", bmem_read, 0);
        chk("rstmid_write", bmem_write, 0);
        chk("rstmid_addr", bmem_addr, 0);
        chk("rstmid_err", err_unexp, 0);
        rst = 0;
        burst(32'h400, l0, 2, 3);
        chk("rstmid_late_err", err_unexp, 1);
        chk("rstmid_late_resp", cl_resp, 0);

        do_reset;
        busy = 0; isw = 0; expr = 0; bk = -1;
        wcnt = '{0, 0}; done_n = '{0, 0};
        for (int cyc = 0; cyc < 4000; cyc++) begin
            allow = cyc < 3000;
            tick;
            chk("rnd_resp", cl_resp, expr);
            for (int i = 0; i < 2; i++) begin
                if (cl_resp[i] && busy[i]) begin
                    if (!isw[i]) chk("rnd_rdata", cl_rdata[i], rdmem(ln(cl_addr[i])));
                    else chk("rnd_wmem", rdmem(ln(cl_addr[i])), cl_wdata[i]);
                    busy[i] = 0; cl_read[i] = 0; cl_write[i] = 0; done_n[i]++;
                end
            end
            expr = 0;
            for (int i = 0; i < 2; i++) begin
                if (!busy[i] && allow && $urandom_range(0, 3) == 0) begin
                    busy[i] = 1; isw[i] = 1'($urandom_range(0, 1)); wcnt[i] = 0;
                    cl_addr[i] = (i == 1 ? 32'h2000 : 32'h1000) + 32'($urandom_range(0, 127));
                    for (int k = 0; k < 8; k++) cl_wdata[i][k*32 +: 32] = $urandom;
                    cl_read[i] = !isw[i]; cl_write[i] = isw[i];
                end
            end
            bmem_ready = $urandom_range(0, 2) != 0;
            if (bk < 0 && rq.size() > 0 && $urandom_range(0, 1) == 1) begin
                idx = $urandom_range(0, rq.size() - 1);
                ba = rq[idx]; rq.delete(idx); bl = rdmem(ba); bk = 0;
            end
            if (bk >= 0) begin
                bmem_rvalid = 1; bmem_raddr = ba; bmem_rdata = bl[bk*BW +: BW];
                if (bk == 3) begin expr[ba[13]] = 1; bk = -1; end
                else bk++;
            end else bmem_rvalid = 0;
            #1;
            if (bmem_read && bmem_ready) begin
                o = bmem_addr[13];
                chk("rnd_rd_owner", busy[o] && !isw[o] && ln(cl_addr[o]) == bmem_addr, 1);
                rq.push_back(bmem_addr);
            end
            if (bmem_write && bmem_ready) begin
                o = bmem_addr[13];
                chk("rnd_wr_owner", busy[o] && isw[o] && ln(cl_addr[o]) == bmem_addr, 1);
                if (wcnt[o] < 4) begin
                    chk("rnd_wbeat", bmem_wdata, cl_wdata[o][wcnt[o]*BW +: BW]);
                    wline[o][wcnt[o]*BW +: BW] = bmem_wdata;
                end
                if (wcnt[o] == 3) begin
                    mem[bmem_addr] = wline[o];
                    expr[o] = 1;
                end
                wcnt[o]++;
            end
        end
        chk("rnd_drained", busy, 0);
        chk("rnd_no_err", err_unexp, 0);
        chk("rnd_done0", done_n[0] > 50, 1);
        chk("rnd_done1", done_n[1] > 50, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
